// File: rtl/calc_pkg.sv
// Shared key codes, FSM states and operation encoding for the calculator core.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'd0;
    localparam logic [3:0] KEY_SUB = 4'd1;
    localparam logic [3:0] KEY_MUL = 4'd2;
    localparam logic [3:0] KEY_DIV = 4'd3;
    localparam logic [3:0] KEY_EQU = 4'd4;
    localparam logic [3:0] KEY_CLR = 4'd5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_B,
        EXEC,
        DONE
    } state_t;

    // Operation codes mirror the low two bits of the operator keys.
    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

endpackage

// File: rtl/calc_seq_muldiv.sv
// Iterative unsigned shift-add multiplier and restoring divider sharing one
// 2*WIDTH accumulator; one iteration per clock, WIDTH iterations per operation.
module calc_seq_muldiv #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               op_is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod_or_qr
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_n;
    logic [WIDTH-1:0]   opnd;
    logic               div_mode;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_borrow;
    logic [WIDTH-1:0]   div_rem;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend shifting into quotient}.
    always_comb begin
        mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_borrow = div_shift < {1'b0, opnd};
        div_rem    = WIDTH'(div_shift - {1'b0, opnd});
        if (div_mode) begin
            acc_n = div_borrow ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {div_rem, acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_n = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            div_mode <= 1'b0;
        end else if (start) begin
            cnt      <= CW'(WIDTH);
            div_mode <= op_is_div;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            acc  <= op_is_div ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
            opnd <= op_is_div ? b : a;
        end else if (cnt != '0) begin
            acc <= acc_n;
        end
    end

    // done marks the cycle doing the final iteration; prod_or_qr is that
    // iteration's outcome so the caller can register it on the same edge.
    assign done       = (cnt == CW'(1));
    assign prod_or_qr = acc_n;

endmodule

// File: rtl/calc_core_param.sv
// WIDTH-bit unsigned calculator core: key-strobe FSM, single-cycle add/sub,
// iterative mul/div via calc_seq_muldiv, registered 2*WIDTH result and flags.
module calc_core_param
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [3:0]         key,
    input  logic [WIDTH-1:0]   data_in,
    output logic               busy,
    output logic [2*WIDTH-1:0] result,
    output logic               result_valid,
    output logic               overflow,
    output logic               div_error
);
    state_t             state;
    state_t             state_n;
    op_t                op;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               key_op;
    logic               key_equ;
    logic               key_clr;
    logic               load_a;
    logic               load_op;
    logic               load_b;
    logic               start_md;
    logic               finish;
    logic               md_done;
    logic [2*WIDTH-1:0] md_result;
    logic [2*WIDTH-1:0] result_n;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;
    logic               b_zero;
    logic               overflow_n;
    logic               div_error_n;

    assign key_op  = key_valid && (key <= KEY_DIV);
    assign key_equ = key_valid && (key == KEY_EQU);
    assign key_clr = key_valid && (key == KEY_CLR);
    assign b_zero  = (b_reg == '0);
    assign busy    = (state == EXEC);

    // The iterative unit loads B straight from data_in on the EQU edge.
    calc_seq_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (start_md),
        .op_is_div (op == OP_DIV),
        .a         (a_reg),
        .b         (data_in),
        .done      (md_done),
        .prod_or_qr(md_result)
    );

    always_comb begin
        state_n  = state;
        load_a   = 1'b0;
        load_op  = 1'b0;
        load_b   = 1'b0;
        start_md = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (key_op) begin
                    load_a  = 1'b1;
                    load_op = 1'b1;
                    state_n = WAIT_B;
                end
            end
            WAIT_B: begin
                if (key_op) begin
                    load_op = 1'b1;
                end else if (key_equ) begin
                    load_b   = 1'b1;
                    start_md = 1'b1;
                    state_n  = EXEC;
                end
            end
            EXEC: begin
                case (op)
                    OP_MUL:  finish = md_done;
                    OP_DIV:  finish = b_zero || md_done;
                    default: finish = 1'b1;
                endcase
                if (finish) state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
        // CLR overrides every transition, including a completion.
        if (key_clr) begin
            state_n  = IDLE;
            load_a   = 1'b0;
            load_op  = 1'b0;
            load_b   = 1'b0;
            start_md = 1'b0;
            finish   = 1'b0;
        end
    end

    always_comb begin
        add_sum     = {1'b0, a_reg} + {1'b0, b_reg};
        sub_diff    = {1'b0, a_reg} - {1'b0, b_reg};
        result_n    = md_result;
        overflow_n  = 1'b0;
        div_error_n = 1'b0;
        case (op)
            OP_ADD: begin
                result_n   = {{(WIDTH-1){1'b0}}, add_sum};
                overflow_n = add_sum[WIDTH];
            end
            OP_SUB: begin
                result_n   = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
                overflow_n = sub_diff[WIDTH];
            end
            OP_DIV: begin
                if (b_zero) begin
                    result_n    = '0;
                    div_error_n = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rst || key_clr) begin
            a_reg        <= '0;
            b_reg        <= '0;
            op           <= OP_ADD;
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            div_error    <= 1'b0;
        end else begin
            if (load_a)  a_reg <= data_in;
            if (load_op) op    <= op_t'(key[1:0]);
            if (load_b)  b_reg <= data_in;
            result_valid <= finish;
            // The outputs change only here; they are held through IDLE.
            if (finish) begin
                result    <= result_n;
                overflow  <= overflow_n;
                div_error <= div_error_n;
            end
        end
    end

endmodule
